// File: rtl/burst_unloader.sv
// -----------------------------------------------------------------------------
// burst_unloader
//
// Read-side companion of the burst loader. A DEPTH x WIDTH word buffer is filled
// through a simple write port while the block is idle. A start command then
// streams the first `length` words, from address 0 upward, over a valid/ready
// interface at one word per cycle. A one-cycle done pulse marks the end of the
// stream, and a one-cycle err pulse marks a start whose length is too large.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   wr_en      in   buffer write strobe (acted on only while idle)
//   wr_addr    in   [AW-1:0]    buffer write address
//   wr_data    in   [WIDTH-1:0] buffer write data
//   start      in   start a stream (sampled only while idle)
//   length     in   [AW:0]      words to stream, 0..DEPTH
//   out_valid  out  out_data carries a word
//   out_ready  in   consumer takes the word when high together with out_valid
//   out_data   out  [WIDTH-1:0] streamed word
//   out_last   out  final word of the stream
//   out_parity out  XOR reduction of out_data (combinational)
//   done       out  one-cycle pulse after the last word is taken
//   idle       out  high while idle
//   err        out  one-cycle pulse on a rejected start
// -----------------------------------------------------------------------------
module burst_unloader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic [AW:0]      length,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_parity,
    output logic             done,
    output logic             idle,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [AW:0]   LP_DEPTH   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LP_LEN_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   LP_LEN_TWO = (AW + 1)'(2);
    localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);

    // Even-parity helper: XOR reduction of a data word.
    function automatic logic f_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // Registered state
    state_t           r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_remaining;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_done;
    logic             r_idle;
    logic             r_err;

    // Next-state values
    state_t           w_state_nxt;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic [AW:0]      w_remaining_nxt;
    logic             w_out_valid_nxt;
    logic [WIDTH-1:0] w_out_data_nxt;
    logic             w_out_last_nxt;
    logic             w_err_nxt;
    logic             w_mem_we;
    logic [WIDTH-1:0] w_word0;
    logic             w_handshake;

    // Writes are honoured only while idle, so the buffer is frozen during a stream.
    assign w_mem_we    = wr_en && (r_state == ST_IDLE);
    // A write to address 0 in the same cycle as start must be the word streamed.
    assign w_word0     = (w_mem_we && (wr_addr == '0)) ? wr_data : r_mem[0];
    assign w_handshake = r_out_valid && out_ready;

    // Buffer storage: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Next-state and next-output logic of the stream FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_remaining_nxt = r_remaining;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_last_nxt  = r_out_last;
        w_err_nxt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        w_state_nxt = ST_DONE;
                    end else if (length > LP_DEPTH) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = ST_STREAM;
                        w_out_valid_nxt = 1'b1;
                        w_out_data_nxt  = w_word0;
                        w_out_last_nxt  = (length == LP_LEN_ONE);
                        w_rd_ptr_nxt    = LP_PTR_ONE;
                        w_remaining_nxt = length;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (w_handshake) begin
                    w_remaining_nxt = r_remaining - LP_LEN_ONE;
                    if (r_remaining > LP_LEN_ONE) begin
                        w_out_data_nxt = r_mem[r_rd_ptr];
                        w_out_last_nxt = (r_remaining == LP_LEN_TWO);
                        // Wraps to 0 after the last address of a full-depth burst; never read again.
                        w_rd_ptr_nxt   = r_rd_ptr + LP_PTR_ONE;
                    end else begin
                        w_out_valid_nxt = 1'b0;
                        w_out_last_nxt  = 1'b0;
                        w_state_nxt     = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_out_valid_nxt = 1'b0;
                w_out_last_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; done/idle are decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_rd_ptr    <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_idle      <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_remaining <= w_remaining_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
            r_done      <= (w_state_nxt == ST_DONE);
            r_idle      <= (w_state_nxt == ST_IDLE);
            r_err       <= w_err_nxt;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign out_parity = f_parity(r_out_data);
    assign done       = r_done;
    assign idle       = r_idle;
    assign err        = r_err;

endmodule

// File: tb/tb_burst_unloader.sv
// -----------------------------------------------------------------------------
// tb_burst_unloader
//
// Directed bench for burst_unloader (WIDTH=8, DEPTH=16). Inputs are driven 1 ns
// after a rising edge and outputs are checked at that same point, so every
// check sees the registers settled after the preceding edge.
// -----------------------------------------------------------------------------
module tb_burst_unloader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_data = 8'd0;
    logic       start = 1'b0;
    logic [4:0] length = 5'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_parity;
    logic       done;
    logic       idle;
    logic       err;

    int checks = 0;
    int errors = 0;

    burst_unloader #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .length     (length),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_parity (out_parity),
        .done       (done),
        .idle       (idle),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int idx;
        logic [7:0] exp_d;

        // ---------------- reset ----------------
        #3 rst = 1'b0;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data",  {24'd0, out_data},  32'd0);
        check("rst_last",  {31'd0, out_last},  32'd0);
        check("rst_done",  {31'd0, done},      32'd0);
        check("rst_err",   {31'd0, err},       32'd0);
        check("rst_idle",  {31'd0, idle},      32'd1);
        tick();
        rst = 1'b1;
        tick();

        // ---------------- fill mem[i] = A0+i ----------------
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 8'(8'hA0 + i);
            tick();
        end
        wr_en = 1'b0;

        // ---------------- length 4, ready held ----------------
        out_ready = 1'b1;
        start     = 1'b1;
        length    = 5'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_d = 8'(8'hA0 + k);
            check("l4_valid", {31'd0, out_valid}, 32'd1);
            check("l4_data",  {24'd0, out_data},  {24'd0, exp_d});
            check("l4_last",  {31'd0, out_last},  (k == 3) ? 32'd1 : 32'd0);
            check("l4_done",  {31'd0, done},      32'd0);
            tick();
        end
        check("l4_done_pulse", {31'd0, done},      32'd1);
        check("l4_valid_off",  {31'd0, out_valid}, 32'd0);
        check("l4_idle_low",   {31'd0, idle},      32'd0);
        tick();
        check("l4_done_end",   {31'd0, done},      32'd0);
        check("l4_idle_back",  {31'd0, idle},      32'd1);

        // ---------------- length 16, ready toggling ----------------
        start  = 1'b1;
        length = 5'd16;
        tick();
        start = 1'b0;
        idx   = 0;
        for (int c = 0; c < 64 && idx < 16; c++) begin
            out_ready = (c % 2 == 0);
            exp_d = 8'(8'hA0 + idx);
            check("l16_valid", {31'd0, out_valid}, 32'd1);
            check("l16_data",  {24'd0, out_data},  {24'd0, exp_d});
            check("l16_last",  {31'd0, out_last},  (idx == 15) ? 32'd1 : 32'd0);
            check("l16_done",  {31'd0, done},      32'd0);
            if (out_ready) idx++;
            tick();
        end
        check("l16_count", idx, 32'd16);
        check("l16_done_pulse", {31'd0, done},      32'd1);
        check("l16_valid_off",  {31'd0, out_valid}, 32'd0);
        tick();
        check("l16_done_end",   {31'd0, done},      32'd0);
        check("l16_idle",       {31'd0, idle},      32'd1);
        out_ready = 1'b1;

        // ---------------- length 0 ----------------
        start  = 1'b1;
        length = 5'd0;
        tick();
        start = 1'b0;
        check("l0_valid", {31'd0, out_valid}, 32'd0);
        check("l0_done",  {31'd0, done},      32'd1);
        check("l0_idle",  {31'd0, idle},      32'd0);
        tick();
        check("l0_done_end", {31'd0, done}, 32'd0);
        check("l0_idle_back", {31'd0, idle}, 32'd1);

        // ---------------- length 17 rejected ----------------
        start  = 1'b1;
        length = 5'd17;
        tick();
        start = 1'b0;
        check("l17_err",   {31'd0, err},       32'd1);
        check("l17_idle",  {31'd0, idle},      32'd1);
        check("l17_done",  {31'd0, done},      32'd0);
        check("l17_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("l17_err_end", {31'd0, err},  32'd0);
        check("l17_no_done", {31'd0, done}, 32'd0);

        // ---------------- write/start ignored mid-stream ----------------
        start  = 1'b1;
        length = 5'd4;
        tick();
        check("ign_d0", {24'd0, out_data}, 32'hA0);
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 8'h55;
        length  = 5'd1;
        tick();
        check("ign_d1", {24'd0, out_data}, 32'hA1);
        tick();
        check("ign_d2", {24'd0, out_data}, 32'hA2);
        check("ign_last2", {31'd0, out_last}, 32'd0);
        wr_en = 1'b0;
        start = 1'b0;
        tick();
        check("ign_d3",    {24'd0, out_data}, 32'hA3);
        check("ign_last3", {31'd0, out_last}, 32'd1);
        tick();
        check("ign_done", {31'd0, done}, 32'd1);
        tick();
        check("ign_idle",  {31'd0, idle},      32'd1);
        check("ign_novld", {31'd0, out_valid}, 32'd0);

        // ---------------- reset mid-stream ----------------
        start  = 1'b1;
        length = 5'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("mid_d3", {24'd0, out_data}, 32'hA3);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_done",  {31'd0, done},      32'd0);
        check("mid_rst_err",   {31'd0, err},       32'd0);
        check("mid_rst_idle",  {31'd0, idle},      32'd1);
        #1 rst = 1'b1;
        tick();
        check("mid_post_done", {31'd0, done}, 32'd0);
        start  = 1'b1;
        length = 5'd2;
        tick();
        start = 1'b0;
        check("rs_d0",   {24'd0, out_data}, 32'hA0);
        check("rs_l0",   {31'd0, out_last}, 32'd0);
        tick();
        check("rs_d1",   {24'd0, out_data}, 32'hA1);
        check("rs_l1",   {31'd0, out_last}, 32'd1);
        tick();
        check("rs_done", {31'd0, done},     32'd1);
        tick();

        // ---------------- parity, write+start same cycle, stall hold ----------------
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 8'h03;
        tick();
        wr_addr   = 4'd0;
        wr_data   = 8'h07;
        start     = 1'b1;
        length    = 5'd2;
        out_ready = 1'b0;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        check("par_d07", {24'd0, out_data},   32'h07);
        check("par_p07", {31'd0, out_parity}, 32'd1);
        tick();
        check("stall_d", {24'd0, out_data},  32'h07);
        check("stall_v", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("par_d03", {24'd0, out_data},   32'h03);
        check("par_p03", {31'd0, out_parity}, 32'd0);
        check("par_l03", {31'd0, out_last},   32'd1);
        tick();
        check("par_done", {31'd0, done}, 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
